// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Buffers keypad codes in a small FIFO and feeds them one at a time to a
// calculator core. It then follows the core's status to collect the display
// digits of a result and recovers from calculator errors.
//
// Parameters
//   FIFO_DEPTH  key FIFO entries (power of two, >= 2)
//   IDLE_CMD    value driven on cmd while cmd_valid is low
//   START_WIN   cycles allowed after an equals command for the core to go busy
//
// Ports
//   clock         in   single clock, rising edge
//   reset         in   synchronous, active-high
//   key_valid     in   keypad code offered
//   key_code[3:0] in   0-9 digit, A/B/C operator, E equals, F clear
//   key_ready     out  FIFO accepts key_code this cycle
//   calc_status   in   0 ERRO, 1 PRONTA, 2 OCUPADA
//   calc_pos[3:0] in   display position being reported (0 = most significant)
//   calc_dig[3:0] in   display digit at calc_pos
//   cmd[3:0]      out  command to calculator
//   cmd_valid     out  cmd is a real command this cycle
//   disp_digits   out  last complete result, bits 31:28 = position 0
//   result_valid  out  one-cycle pulse when disp_digits is updated
//   err_flag      out  calculator error is being recovered
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// IDLE       | wait for PRONTA and a queued key; pop it into cmd_reg
// ISSUE      | drive cmd_reg for one cycle
// WAIT_START | after equals, wait up to START_WIN cycles for OCUPADA
// COLLECT    | capture display digits until the core returns to PRONTA
// RECOVER    | send one clear command, wait for PRONTA
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] IDLE_CMD   = 4'hD,
  parameter int         START_WIN  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  input  logic [1:0]  calc_status,
  input  logic [3:0]  calc_pos,
  input  logic [3:0]  calc_dig,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  output logic [31:0] disp_digits,
  output logic        result_valid,
  output logic        err_flag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_ERRO    = 2'd0;
  localparam logic [1:0] ST_PRONTA  = 2'd1;
  localparam logic [1:0] ST_OCUPADA = 2'd2;

  localparam logic [3:0] KEY_EQUALS = 4'hE;
  localparam logic [3:0] KEY_CLEAR  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_COLLECT,
    S_RECOVER
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic [3:0]  cmd_reg;
  logic [7:0]  win_cnt;
  logic [31:0] shadow;
  logic        rec_first;

  logic        push;
  logic        pop;
  logic        status_err;
  logic        win_last;
  logic [4:0]  nib_lsb;

  // An error is acted on everywhere except while already recovering.
  assign status_err = (calc_status == ST_ERRO) && (state != S_RECOVER);

  // key_ready uses the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign key_ready = (fifo_count < CNT_W'(FIFO_DEPTH)) && (state != S_RECOVER);
  assign push      = key_valid && key_ready;
  assign pop       = (state == S_IDLE) && (calc_status == ST_PRONTA) &&
                     (fifo_count != '0);

  // Last cycle of the start window: the incremented count reaches START_WIN.
  assign win_last = ({1'b0, win_cnt} + 9'd1) >= 9'(START_WIN);

  // Position 0 lives in the top nibble: lsb = (7 - pos) * 4.
  assign nib_lsb = {~calc_pos[2:0], 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (status_err) begin
      state_nxt = S_RECOVER;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          state_nxt = (cmd_reg == KEY_EQUALS) ? S_WAIT_START : S_IDLE;
        end
        S_WAIT_START: begin
          if (calc_status == ST_OCUPADA) state_nxt = S_COLLECT;
          else if (win_last)             state_nxt = S_IDLE;
        end
        S_COLLECT: begin
          // No timeout here: long operations may stay busy indefinitely.
          if (calc_status == ST_PRONTA) state_nxt = S_IDLE;
        end
        S_RECOVER: begin
          if (calc_status == ST_PRONTA) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd       = IDLE_CMD;
    cmd_valid = 1'b0;
    if (state == S_ISSUE) begin
      cmd       = cmd_reg;
      cmd_valid = 1'b1;
    end else if ((state == S_RECOVER) && rec_first) begin
      cmd       = KEY_CLEAR;
      cmd_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || status_err) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Command register, start window counter, result capture, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_reg      <= IDLE_CMD;
      win_cnt      <= '0;
      shadow       <= '0;
      disp_digits  <= '0;
      result_valid <= 1'b0;
      err_flag     <= 1'b0;
      rec_first    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (pop) begin
        cmd_reg <= fifo_mem[rd_ptr];
      end
      if (status_err) begin
        // Partial result is dropped; the displayed result is kept.
        err_flag  <= 1'b1;
        rec_first <= 1'b1;
        shadow    <= '0;
      end else begin
        case (state)
          S_ISSUE: begin
            win_cnt <= '0;
          end
          S_WAIT_START: begin
            win_cnt <= win_cnt + 8'd1;
          end
          S_COLLECT: begin
            if (calc_status == ST_PRONTA) begin
              disp_digits  <= shadow;
              result_valid <= 1'b1;
              shadow       <= '0;
            end else if ((calc_status == ST_OCUPADA) && !calc_pos[3]) begin
              shadow[nib_lsb +: 4] <= calc_dig;
            end
          end
          S_RECOVER: begin
            rec_first <= 1'b0;
            if (calc_status == ST_PRONTA) err_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  localparam int         FIFO_DEPTH = 8;
  localparam logic [3:0] IDLE_CMD   = 4'hD;
  localparam int         START_WIN  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [1:0]  calc_status;
  logic [3:0]  calc_pos;
  logic [3:0]  calc_dig;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic [31:0] disp_digits;
  logic        result_valid;
  logic        err_flag;

  calc_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDLE_CMD   (IDLE_CMD),
    .START_WIN  (START_WIN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .calc_status  (calc_status),
    .calc_pos     (calc_pos),
    .calc_dig     (calc_dig),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .disp_digits  (disp_digits),
    .result_valid (result_valid),
    .err_flag     (err_flag)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;
  int rv_pulses = 0;

  logic [3:0] obs_cmd [$];
  int         obs_cyc [$];
  logic [3:0] exp_cmd [$];
  logic [31:0] last_disp;

  // Monitor: every issued command with its cycle number, and result pulses.
  always @(negedge clock) begin
    cyc_no = cyc_no + 1;
    if (!reset && cmd_valid) begin
      obs_cmd.push_back(cmd);
      obs_cyc.push_back(cyc_no);
    end
    if (!reset && result_valid) rv_pulses = rv_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clear_mon();
    obs_cmd.delete();
    obs_cyc.delete();
    exp_cmd.delete();
    rv_pulses = 0;
  endtask

  task automatic push_key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int budget, input string tag);
    int n;
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd === c) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_seen"}, 32'(n < budget), 32'd1);
  endtask

  // Issued command stream versus the keys queued, plus the 2-cycle spacing
  // (the clear command on error is allowed to follow immediately).
  task automatic check_cmds(input string tag);
    int n;
    check({tag, "_ncmd"}, 32'(obs_cmd.size()), 32'(exp_cmd.size()));
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_cmd%0d", tag, i), 32'(obs_cmd[i]), 32'(exp_cmd[i]));
      if (i > 0 && obs_cmd[i] != 4'hF)
        check($sformatf("%s_gap%0d", tag, i), 32'((obs_cyc[i] - obs_cyc[i-1]) >= 2), 32'd1);
    end
  endtask

  // Called in the first COLLECT cycle. Positions whose mask bit is set are
  // reported; the others are reported as position 8+p and must be ignored.
  task automatic collect(input string tag, input logic [31:0] val,
                         input logic [7:0] mask, output logic [31:0] exp);
    exp = 32'h0;
    for (int p = 0; p < 8; p++) begin
      calc_status = 2'd2;
      calc_dig    = val[28-4*p +: 4];
      if (mask[p]) begin
        calc_pos = 4'(p);
        exp[28-4*p +: 4] = val[28-4*p +: 4];
      end else begin
        calc_pos = 4'(8 + p);
      end
      cyc();
    end
    calc_status = 2'd1;
    cyc();
    check({tag, "_rv"}, 32'(result_valid), 32'd1);
    check({tag, "_disp"}, disp_digits, exp);
    cyc();
    check({tag, "_rv_off"}, 32'(result_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    check({tag, "_cmd"}, 32'(cmd), 32'(IDLE_CMD));
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_disp"}, disp_digits, 32'h0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_err"}, 32'(err_flag), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_val;
    logic [31:0] rnd_val;
    logic [7:0]  rnd_mask;
    logic [3:0]  k;
    int          nk;

    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    calc_status = 2'd1;
    calc_pos    = 4'h0;
    calc_dig    = 4'h0;
    repeat (3) cyc();
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc();
    last_disp = 32'h0;

    // Addition 12+34 style sequence with a fixed display result.
    clear_mon();
    exp_cmd = '{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'hE};
    foreach (exp_cmd[i]) push_key(exp_cmd[i]);
    wait_cmd(4'hE, 40, "add");
    calc_status = 2'd2;
    calc_pos    = 4'hF;
    cyc();
    cyc();
    collect("add", 32'h00000046, 8'hFF, exp_val);
    check("add_value", exp_val, 32'h00000046);
    last_disp = exp_val;
    check_cmds("add");
    check("add_pulses", 32'(rv_pulses), 32'd1);

    // Random keys; busy arrives on the last cycle of the start window.
    clear_mon();
    nk = int'($urandom_range(2, 5));
    for (int i = 0; i < nk; i++) exp_cmd.push_back(4'($urandom_range(0, 12)));
    exp_cmd.push_back(4'hE);
    foreach (exp_cmd[i]) push_key(exp_cmd[i]);
    wait_cmd(4'hE, 60, "late");
    repeat (START_WIN) cyc();
    calc_status = 2'd2;
    calc_pos    = 4'hF;
    cyc();
    rnd_val  = $urandom;
    rnd_mask = 8'($urandom_range(1, 255));
    collect("late", rnd_val, rnd_mask, exp_val);
    last_disp = exp_val;
    check_cmds("late");
    check("late_pulses", 32'(rv_pulses), 32'd1);

    // Error after equals, with keys still queued behind it.
    clear_mon();
    exp_cmd = '{4'h5, 4'hC, 4'h0, 4'hE, 4'hF};
    push_key(4'h5); push_key(4'hC); push_key(4'h0); push_key(4'hE);
    push_key(4'h7); push_key(4'h8);
    wait_cmd(4'hE, 40, "err");
    calc_status = 2'd0;
    cyc();
    check("err_flag_set", 32'(err_flag), 32'd1);
    check("err_clear_cmd", 32'(cmd), 32'hF);
    check("err_clear_valid", 32'(cmd_valid), 32'd1);
    check("err_key_ready", 32'(key_ready), 32'd0);
    cyc();
    check("err_cmd_idle", 32'(cmd), 32'(IDLE_CMD));
    check("err_valid_low", 32'(cmd_valid), 32'd0);
    check("err_flag_hold", 32'(err_flag), 32'd1);
    key_valid = 1'b1;
    key_code  = 4'h9;
    cyc();
    key_valid   = 1'b0;
    calc_status = 2'd1;
    cyc();
    check("err_flag_clear", 32'(err_flag), 32'd0);
    repeat (12) cyc();
    check_cmds("err");
    check("err_disp_kept", disp_digits, last_disp);
    check("err_pulses", 32'(rv_pulses), 32'd0);

    // Backpressure: fill while busy, then push and pop together when full.
    clear_mon();
    calc_status = 2'd2;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      k = 4'($urandom_range(0, 9));
      check($sformatf("bp_ready%0d", i), 32'(key_ready), 32'd1);
      exp_cmd.push_back(k);
      push_key(k);
    end
    check("bp_full_ready", 32'(key_ready), 32'd0);
    key_valid = 1'b1;
    key_code  = 4'h1;
    cyc();
    calc_status = 2'd1;
    key_code    = 4'h2;
    check("bp_pushpop_ready", 32'(key_ready), 32'd0);
    cyc();
    key_valid = 1'b0;
    repeat (30) cyc();
    check_cmds("bp");
    check("bp_drained_ready", 32'(key_ready), 32'd1);

    // Equals with no busy response: times out, next key follows.
    clear_mon();
    exp_cmd = '{4'hE, 4'h7};
    push_key(4'hE);
    push_key(4'h7);
    repeat (30) cyc();
    check_cmds("nostart");
    if (obs_cyc.size() >= 2)
      check("nostart_window", 32'(obs_cyc[1] - obs_cyc[0]), 32'(START_WIN + 2));
    check("nostart_pulses", 32'(rv_pulses), 32'd0);
    check("nostart_disp", disp_digits, last_disp);
    check("nostart_err", 32'(err_flag), 32'd0);

    // Reset in the middle of collection, with keys queued.
    clear_mon();
    push_key(4'hE);
    wait_cmd(4'hE, 20, "mid");
    calc_status = 2'd2;
    calc_pos    = 4'hF;
    cyc();
    cyc();
    for (int p = 0; p < 3; p++) begin
      calc_pos  = 4'(p);
      calc_dig  = 4'h9;
      key_valid = 1'b1;
      key_code  = 4'(3 + p);
      cyc();
    end
    key_valid = 1'b0;
    reset     = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    clear_mon();
    reset       = 1'b0;
    calc_status = 2'd1;
    repeat (10) cyc();
    check_cmds("midrst_flushed");
    last_disp = 32'h0;

    exp_cmd.push_back(4'hE);
    push_key(4'hE);
    wait_cmd(4'hE, 20, "post");
    calc_status = 2'd2;
    calc_pos    = 4'hF;
    cyc();
    cyc();
    rnd_val = $urandom | 32'h11111111;
    collect("post", rnd_val, 8'hF8, exp_val);
    check("post_no_stale", 32'(exp_val[31:20]), 32'h0);
    check_cmds("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, key FIFO entries (power of two).
REQ-002 Parameter IDLE_CMD, default 4'hD, cmd value driven while cmd_valid=0.
REQ-003 Parameter START_WIN, default 4, cycles allowed after an equals command for calc_status to reach OCUPADA.
REQ-004 clock  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 key_valid  in  1  keypad code offered.
REQ-007 key_code  in  4  code: 0-9 digit, A/B/C op, E equals, F clear.
REQ-008 key_ready  out  1  FIFO accepts key_code this cycle.
REQ-009 calc_status  in  2  calculator state: 0 ERRO, 1 PRONTA, 2 OCUPADA.
REQ-010 calc_pos  in  4  calculator display position.
REQ-011 calc_dig  in  4  calculator display digit.
REQ-012 cmd  out  4  command to calculator.
REQ-013 cmd_valid  out  1  cmd is a real command this cycle.
REQ-014 disp_digits  out  32  result, nibble 7 (bits 31:28) = position 0 (most significant).
REQ-015 result_valid  out  1  one-cycle pulse, new disp_digits.
REQ-016 err_flag  out  1  calculator error being recovered.

Function
REQ-017 Key FIFO SHALL push on key_valid && key_ready; key_ready = (count < FIFO_DEPTH) && state != RECOVER.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; on full, a pop in the same cycle SHALL NOT enable a push (key_ready depends on registered count only).
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_START, COLLECT, RECOVER.
REQ-020 IDLE: if calc_status==1 and FIFO non-empty, pop the head into a command register and go to ISSUE; otherwise stay IDLE.
REQ-021 ISSUE: drive cmd=command register and cmd_valid=1 for exactly one cycle; go to WAIT_START if the command is 4'hE, else IDLE.
REQ-022 Consecutive commands SHALL be at least 2 cycles apart; maximum throughput is one command per 2 cycles.
REQ-023 In every state except ISSUE and RECOVER's issue cycle, cmd SHALL equal IDLE_CMD and cmd_valid SHALL be 0.
REQ-024 WAIT_START: an 8-bit cycle counter starts at 0; calc_status==2 -> COLLECT; counter reaching START_WIN with status still 1 -> IDLE with no result_valid.
REQ-025 COLLECT: each cycle with calc_status==2 and calc_pos<8, capture calc_dig into a shadow buffer nibble selected by calc_pos; positions 8-15 SHALL be ignored.
REQ-026 COLLECT: calc_status==1 SHALL copy the shadow buffer to disp_digits, pulse result_valid for one cycle, clear the shadow buffer and go to IDLE.
REQ-027 COLLECT has no timeout; multiplication may keep OCUPADA for an unbounded number of cycles.
REQ-028 From any state other than RECOVER, calc_status==0 SHALL set err_flag, flush the FIFO (count=0) and enter RECOVER.
REQ-029 RECOVER: the first cycle SHALL drive cmd=4'hF with cmd_valid=1; afterwards cmd SHALL be idle; on calc_status==1, clear err_flag and go to IDLE.
REQ-030 disp_digits SHALL be unchanged by errors and by a START_WIN timeout.
REQ-031 A key popped while status is non-PRONTA is impossible; the head SHALL remain queued until PRONTA.

Reset
REQ-032 On reset: state IDLE, FIFO empty, key_ready=1, cmd=IDLE_CMD, cmd_valid=0, disp_digits=0, result_valid=0, err_flag=0, shadow buffer=0, counters 0.
REQ-033 Reset SHALL take effect in any state, including mid-COLLECT or RECOVER, and discard any queued keys and partial results.

Verification
REQ-034 Addition: push 1,2,A,3,4,E with status PRONTA; model drives OCUPADA with pos 0-7 digits 0,0,0,0,0,0,4,6 -> cmd sequence 1,2,A,3,4,E at 2-cycle spacing, disp_digits=32'h00000046, one result_valid pulse.
REQ-035 Error: push 5,C,0,E; model returns status 0 after E -> err_flag=1, FIFO empty, single cmd=F with cmd_valid, err_flag drops when status returns to 1.
REQ-036 Backpressure: status held 2, push 9 keys -> key_ready=0 after the 8th push, 9th not accepted; with count=8, push and pop in the same cycle -> push rejected.
REQ-037 No-start: push E, status stays 1 -> IDLE after START_WIN=4 cycles, no result_valid, disp_digits unchanged.
REQ-038 Reset mid-COLLECT after 3 digits captured -> all outputs at REQ-032 values next cycle; a later full result contains no stale nibbles.
